instr_fetch_align: RTL and testbench

Fetch-side aligner sitting directly upstream of the compressed-instruction expander. Issues word-aligned 32-bit fetches to instruction memory and buffers returned halfwords. Presents one whole instruction per handshake (16-bit compressed or 32-bit, possibly straddling a word boundary) with its PC. Handles pipeline redirects (branch/jump), including targets at odd halfword addresses.

---
 rtl/rv32ic_fetch_pkg.sv | 25 ++
 rtl/fetch_hw_queue.sv | 78 +++++++
 rtl/instr_fetch_align.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_align.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ic_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32ic_fetch_pkg
//  Purpose  : Shared types and helpers for the instruction fetch aligner.
//  Revision : 1.0  initial release
// ============================================================================
package rv32ic_fetch_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  localparam int QDEPTH = 4;

  // RVC encoding: a halfword whose two LSBs are not 2'b11 starts a 16-bit instruction
  function automatic logic is_compressed(halfword_t hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hw_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_hw_queue
//  Purpose  : 4-entry halfword FIFO. Accepts one or two halfwords per cycle,
//             releases one or two per cycle, and exposes the two oldest
//             entries so a whole instruction can be read in one go.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_hw_queue
  import rv32ic_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push1_i,      // push upper halfword of push_data_i only
  input  logic        push2_i,      // push lower then upper halfword
  input  logic [31:0] push_data_i,
  input  logic        pop1_i,
  input  logic        pop2_i,
  output logic [2:0]  count_o,
  output logic [15:0] head0_o,
  output logic [15:0] head1_o
);

  halfword_t  entry_q [QDEPTH];
  halfword_t  entry_d [QDEPTH];
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic [2:0] w_pop_n;
  logic [2:0] w_base;
  logic [2:0] w_src;

  // Entry 0 is always the head: pops shift the array down, pushes land
  // just past the surviving entries. Pop is applied before push so that
  // both can happen in the same cycle.
  always_comb begin
    w_pop_n = pop2_i ? 3'd2 : (pop1_i ? 3'd1 : 3'd0);
    w_base  = count_q - w_pop_n;
    w_src   = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_src      = 3'(i) + w_pop_n;
      entry_d[i] = (w_src < 3'(QDEPTH)) ? entry_q[w_src[1:0]] : entry_q[i];
    end
    count_d = w_base;
    if (push2_i) begin
      entry_d[w_base[1:0]]         = push_data_i[15:0];
      entry_d[w_base[1:0] + 2'd1]  = push_data_i[31:16];
      count_d                      = w_base + 3'd2;
    end else if (push1_i) begin
      entry_d[w_base[1:0]]         = push_data_i[31:16];
      count_d                      = w_base + 3'd1;
    end
    if (clear_i) begin
      count_d = '0;
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < QDEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign count_o = count_q;
  assign head0_o = entry_q[0];
  assign head1_o = entry_q[1];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_align
//  Purpose  : Issues word-aligned fetches, buffers returned halfwords and
//             presents one whole 16/32-bit instruction per handshake with its
//             PC. Handles redirects to any halfword-aligned target.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_align
  import rv32ic_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  output logic        fetch_valid,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  hd_pc_q;
  logic [31:0]  hd_pc_d;
  logic [31:0]  fetch_addr_q;
  logic [31:0]  fetch_addr_d;
  logic         skip_q;
  logic         skip_d;

  logic         w_clear;
  logic         w_push1;
  logic         w_push2;
  logic         w_pop1;
  logic         w_pop2;
  logic [2:0]   w_count;
  logic [15:0]  w_head0;
  logic [15:0]  w_head1;
  logic         w_head_c;
  logic         w_fetch_fire;
  logic         w_instr_fire;
  logic         w_outstanding;

  fetch_hw_queue u_queue (
    .clk         (aclk),
    .rst         (areset),
    .clear_i     (w_clear),
    .push1_i     (w_push1),
    .push2_i     (w_push2),
    .push_data_i (rsp_data),
    .pop1_i      (w_pop1),
    .pop2_i      (w_pop2),
    .count_o     (w_count),
    .head0_o     (w_head0),
    .head1_o     (w_head1)
  );

  // Output decode: only queue registers and hd_pc feed the instruction side
  assign w_head_c         = is_compressed(w_head0);
  assign instr_valid      = (w_count >= 3'd2) || ((w_count == 3'd1) && w_head_c);
  assign instr_word       = w_head_c ? {16'h0000, w_head0} : {w_head1, w_head0};
  assign instr_pc         = hd_pc_q;
  assign instr_compressed = w_head_c;

  // Keep room for a full word before requesting; held low throughout reset
  assign fetch_valid  = (state_q == F_IDLE) && (w_count <= 3'd2) && !areset;
  assign fetch_addr   = fetch_addr_q;
  assign w_fetch_fire = fetch_valid && fetch_ready;
  assign w_instr_fire = instr_valid && instr_ready;

  // Next-state logic: redirect overrides every other same-cycle event
  always_comb begin
    state_d       = state_q;
    hd_pc_d       = hd_pc_q;
    fetch_addr_d  = fetch_addr_q;
    skip_d        = skip_q;
    w_clear       = 1'b0;
    w_push1       = 1'b0;
    w_push2       = 1'b0;
    w_pop1        = 1'b0;
    w_pop2        = 1'b0;
    w_outstanding = 1'b0;

    if (redirect) begin
      w_clear      = 1'b1;
      hd_pc_d      = redirect_pc & ~32'd1;
      fetch_addr_d = redirect_pc & ~32'd3;
      skip_d       = redirect_pc[1];
      // A request still in flight after this edge must have its response dropped;
      // a response arriving this cycle retires the old request by itself.
      case (state_q)
        F_IDLE:         w_outstanding = w_fetch_fire;
        F_WAIT, F_DROP: w_outstanding = !rsp_valid;
        default:        w_outstanding = 1'b0;
      endcase
      state_d = w_outstanding ? F_DROP : F_IDLE;
    end else begin
      case (state_q)
        F_IDLE: begin
          if (w_fetch_fire) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            state_d      = F_WAIT;
          end
        end
        F_WAIT: begin
          if (rsp_valid) begin
            w_push1 = skip_q;
            w_push2 = !skip_q;
            skip_d  = 1'b0;
            state_d = F_IDLE;
          end
        end
        F_DROP: begin
          if (rsp_valid) begin
            state_d = F_IDLE;
          end
        end
        default: state_d = F_IDLE;
      endcase

      if (w_instr_fire) begin
        if (w_head_c) begin
          w_pop1  = 1'b1;
          hd_pc_d = hd_pc_q + 32'd2;
        end else begin
          w_pop2  = 1'b1;
          hd_pc_d = hd_pc_q + 32'd4;
        end
      end
    end
  end

  // FSM state, PC and skip registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= F_IDLE;
      hd_pc_q      <= RESET_PC;
      fetch_addr_q <= RESET_PC & ~32'd3;
      skip_q       <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      hd_pc_q      <= hd_pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_align
//  Purpose  : Randomized self-checking bench for instr_fetch_align. A memory
//             model answers fetches; an instruction-stream model walks the
//             memory image by PC and predicts every delivered instruction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_align;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  instr_fetch_align #(.RESET_PC(RESET_PC)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .fetch_valid      (fetch_valid),
    .fetch_addr       (fetch_addr),
    .fetch_ready      (fetch_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_word       (instr_word),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed)
  );

  always #5 aclk = ~aclk;

  // Scoreboard state
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] mem [128];
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] hs_word [$];
  logic [31:0] hs_pc   [$];
  int          cyc = 0;
  int          n_instr = 0;
  int          first_acc_cyc = -1;
  int          first_iv_cyc  = -1;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_faddr = '0;
  logic        acc_this = 1'b0;
  logic        obs_fvalid = 1'b0;
  logic        obs_ivalid = 1'b0;

  // Stimulus knobs
  int          p_ready  = 100;
  int          p_fready = 100;
  int          p_redir  = 0;
  int          min_lat  = 1;
  int          max_lat  = 1;
  logic        redir_now = 1'b0;
  logic [31:0] redir_target = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rnd(input int p);
    return ($urandom_range(99, 0) < p);
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'h0) return 32'hFFFF_FF00 | {24'h0, r[31:24]};
    return {23'h0, r[31:23]};
  endfunction

  task automatic fill_mem_random();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  // One clock: sample outputs, update models, drive inputs for the next edge
  task automatic step();
    logic [15:0] hw0;
    logic [31:0] ew;
    logic [31:0] nxt;
    logic [31:0] ra;
    logic [31:0] rt;
    logic        ec;
    logic        fr;
    logic        ir;
    logic        rd;
    int          lat;
    @(negedge aclk);
    #1;
    cyc++;
    acc_this   = 1'b0;
    obs_fvalid = fetch_valid;
    obs_ivalid = instr_valid;
    if (prev_stall && !prev_redir) chk_eq("faddr_hold", fetch_addr, prev_faddr);

    fr = rnd(p_fready);
    ir = rnd(p_ready);
    rd = redir_now || rnd(p_redir);
    rt = redir_now ? redir_target : rand_target();
    redir_now = 1'b0;

    rsp_valid = 1'b0;
    rsp_data  = $urandom;
    if (pend_addr.size() > 0 && cyc >= pend_due[0]) begin
      ra        = pend_addr.pop_front();
      void'(pend_due.pop_front());
      rsp_valid = 1'b1;
      rsp_data  = mem[ra[8:2]];
    end

    if (fetch_valid && fr) begin
      chk_eq("fetch_addr", fetch_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      lat = $urandom_range(max_lat, min_lat);
      pend_addr.push_back(fetch_addr);
      pend_due.push_back(cyc + lat);
      acc_this = 1'b1;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end

    if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;

    if (instr_valid && ir && !rd) begin
      hw0 = mem_hw(exp_pc);
      if (hw0[1:0] != 2'b11) begin
        ew  = {16'h0000, hw0};
        ec  = 1'b1;
        nxt = exp_pc + 32'd2;
      end else begin
        ew  = {mem_hw(exp_pc + 32'd2), hw0};
        ec  = 1'b0;
        nxt = exp_pc + 32'd4;
      end
      chk_eq("instr_pc", instr_pc, exp_pc);
      chk_eq("instr_word", instr_word, ew);
      chk_eq("instr_comp", {31'h0, instr_compressed}, {31'h0, ec});
      hs_word.push_back(instr_word);
      hs_pc.push_back(instr_pc);
      exp_pc = nxt;
      n_instr++;
    end

    if (rd) begin
      exp_pc    = rt & ~32'd1;
      exp_fetch = rt & ~32'd3;
    end

    fetch_ready = fr;
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rt;
    prev_stall  = fetch_valid && !fr;
    prev_faddr  = fetch_addr;
    prev_redir  = rd;
  endtask

  // Asynchronous reset pulse; outputs must fall back while it is held
  task automatic do_reset();
    @(negedge aclk);
    #1;
    areset      = 1'b1;
    fetch_ready = 1'b0;
    rsp_valid   = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk_eq("rst_fvalid", {31'h0, fetch_valid}, 32'h0);
    chk_eq("rst_ivalid", {31'h0, instr_valid}, 32'h0);
    chk_eq("rst_pc", instr_pc, RESET_PC);
    chk_eq("rst_faddr", fetch_addr, RESET_PC & ~32'd3);
    pend_addr.delete();
    pend_due.delete();
    hs_word.delete();
    hs_pc.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk_eq("rel_fvalid", {31'h0, fetch_valid}, 32'h1);
    chk_eq("rel_ivalid", {31'h0, instr_valid}, 32'h0);
    exp_pc        = RESET_PC;
    exp_fetch     = RESET_PC & ~32'd3;
    prev_stall    = 1'b0;
    prev_redir    = 1'b0;
    first_acc_cyc = -1;
    first_iv_cyc  = -1;
  endtask

  task automatic run_instr(input int n, input int budget);
    int start;
    int c;
    start = n_instr;
    c = 0;
    while ((n_instr - start) < n && c < budget) begin
      step();
      c++;
    end
    if ((n_instr - start) < n) chk_eq("progress", n_instr - start, n);
  endtask

  task automatic set_knobs(input int pr, input int pf, input int pd, input int lmin, input int lmax);
    p_ready  = pr;
    p_fready = pf;
    p_redir  = pd;
    min_lat  = lmin;
    max_lat  = lmax;
  endtask

  initial begin
    int a;
    int k;
    areset      = 1'b1;
    fetch_ready = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Single 32-bit instruction at the reset PC, 1-cycle memory
    fill_mem_random();
    mem[0] = 32'h0001_0513;
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    run_instr(1, 30);
    chk_eq("tp1_word", hs_word[0], 32'h0001_0513);
    chk_eq("tp1_pc", hs_pc[0], 32'h0);
    chk_eq("tp1_latency", first_iv_cyc - first_acc_cyc, 2);

    // Two compressed instructions in one word
    mem[0] = 32'h4501_0505;
    do_reset();
    run_instr(2, 30);
    chk_eq("tp2_w0", hs_word[0], 32'h0000_0505);
    chk_eq("tp2_pc0", hs_pc[0], 32'h0);
    chk_eq("tp2_w1", hs_word[1], 32'h0000_4501);
    chk_eq("tp2_pc1", hs_pc[1], 32'h2);

    // 32-bit instruction straddling a word boundary, slow memory
    mem[0] = 32'h0513_0505;
    mem[1] = 32'hABCD_0001;
    set_knobs(100, 100, 0, 3, 3);
    do_reset();
    run_instr(2, 40);
    chk_eq("tp3_w1", hs_word[1], 32'h0001_0513);
    chk_eq("tp3_pc1", hs_pc[1], 32'h2);

    // Redirect to an odd-halfword target while a fetch is pending
    mem[64] = 32'h0505_FFFF;
    do_reset();
    step();
    redir_now    = 1'b1;
    redir_target = 32'h0000_0102;
    step();
    hs_word.delete();
    hs_pc.delete();
    run_instr(1, 50);
    chk_eq("tp4_pc", hs_pc[0], 32'h0000_0102);
    chk_eq("tp4_word", hs_word[0], 32'h0000_0505);

    // Steady-state throughput of a 32-bit stream
    for (int i = 0; i < 128; i++) mem[i] = 32'h0001_0513;
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (10) step();
    a = n_instr;
    repeat (20) step();
    chk_eq("throughput", n_instr - a, 10);

    // Randomized traffic with redirects
    fill_mem_random();
    set_knobs(70, 70, 4, 1, 3);
    do_reset();
    run_instr(400, 6000);

    // Reset while a response is pending
    set_knobs(70, 100, 0, 3, 3);
    k = 0;
    do begin
      step();
      k++;
    end while (!acc_this && k < 50);
    do_reset();
    set_knobs(70, 70, 4, 1, 3);
    run_instr(200, 3000);

    // Downstream stall with streaming memory, then release
    set_knobs(0, 100, 0, 1, 2);
    repeat (40) step();
    chk_eq("stall_fvalid", {31'h0, obs_fvalid}, 32'h0);
    chk_eq("stall_ivalid", {31'h0, obs_ivalid}, 32'h1);
    set_knobs(100, 100, 0, 1, 2);
    run_instr(50, 400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
